// File: rtl/fft16_frame_ctrl.sv
// Frame sequencer for the 16-point FFT datapath: gathers 16 real samples,
// launches the datapath, and streams the result back in natural bin order.
module fft16_frame_ctrl #(
  parameter int PIPE_LAT = 2,
  parameter int N        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_data,
  output logic              fft_start,
  output logic [N*32-1:0]   fft_in_bus,
  input  logic [N*32-1:0]   fft_out_bus,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [3:0]        out_idx,
  output logic              frame_done
);

  localparam logic [3:0] LAT = 4'(PIPE_LAT);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WAIT, S_DRAIN} state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic [3:0]      wcnt;
  logic [N*32-1:0] frame;
  logic [N*32-1:0] out_buf;
  logic [3:0]      next_idx;
  logic            accept;

  function automatic logic [3:0] bitrev4(input logic [3:0] k);
    return {k[0], k[1], k[2], k[3]};
  endfunction

  assign accept     = in_valid && in_ready;
  assign next_idx   = out_idx + 4'd1;
  assign fft_in_bus = frame;
  // Must coincide with the k=15 transfer itself, so it cannot be registered.
  assign frame_done = out_valid && out_ready && (out_idx == 4'd15);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      wcnt      <= 4'd0;
      in_ready  <= 1'b0;
      fft_start <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= 4'd0;
      out_data  <= 32'd0;
      frame     <= '0;
      out_buf   <= '0;
    end else begin
      fft_start <= 1'b0;
      case (state)
        S_IDLE, S_COLLECT: begin
          in_ready <= 1'b1;
          if (accept) begin
            frame[{cnt, 5'b0} +: 32] <= {in_data, 16'h0000};
            cnt <= cnt + 4'd1;
            if (cnt == 4'd15) begin
              // cnt wraps to 0 here, ready for the next frame.
              state     <= S_WAIT;
              in_ready  <= 1'b0;
              fft_start <= 1'b1;
              wcnt      <= 4'd0;
            end else begin
              state <= S_COLLECT;
            end
          end
        end
        S_WAIT: begin
          if (wcnt == LAT) begin
            out_buf   <= fft_out_bus;
            out_data  <= fft_out_bus[31:0];
            out_idx   <= 4'd0;
            out_valid <= 1'b1;
            state     <= S_DRAIN;
          end else begin
            wcnt <= wcnt + 4'd1;
          end
        end
        S_DRAIN: begin
          if (out_valid && out_ready) begin
            if (out_idx == 4'd15) begin
              out_valid <= 1'b0;
              out_idx   <= 4'd0;
              out_data  <= 32'd0;
              in_ready  <= 1'b1;
              state     <= S_IDLE;
            end else begin
              // Slot j of the datapath result holds bin bitrev4(j).
              out_idx  <= next_idx;
              out_data <= out_buf[{bitrev4(next_idx), 5'b0} +: 32];
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft16_frame_ctrl.sv
// Directed bench for fft16_frame_ctrl using delay-line stubs in place of the
// FFT datapath; one task per scenario, each with its own inline checks.
module tb_fft16_frame_ctrl;

  localparam int PL = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0;
  logic        out_ready = 1'b0;
  logic        in_ready, fft_start, out_valid, frame_done;
  logic [511:0] fft_in_bus, fft_out_bus;
  logic [31:0] out_data;
  logic [3:0]  out_idx;

  always #5 clk = ~clk;

  // Stub datapath: result is the input bus delayed PL cycles.
  logic [511:0] pipe [PL];
  always @(posedge clk) begin
    pipe[0] <= fft_in_bus;
    for (int i = 1; i < PL; i++) pipe[i] <= pipe[i-1];
  end
  assign fft_out_bus = pipe[PL-1];

  fft16_frame_ctrl #(.PIPE_LAT(PL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .fft_start(fft_start), .fft_in_bus(fft_in_bus),
    .fft_out_bus(fft_out_bus), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .frame_done(frame_done)
  );

  // Extra instances: PIPE_LAT=1, PIPE_LAT=15, and PIPE_LAT=2 fed by a 3-cycle stub.
  logic        in_valid_b = 1'b0;
  logic [15:0] in_data_b = 16'h0;
  logic        out_ready_b = 1'b1;
  logic        x_in_ready [3];
  logic        x_fft_start [3];
  logic        x_out_valid [3];
  logic        x_fd [3];
  logic [511:0] x_in_bus [3];
  logic [511:0] x_out_bus [3];
  logic [31:0] x_out_data [3];
  logic [3:0]  x_out_idx [3];
  logic [511:0] p1 [1];
  logic [511:0] p15 [15];
  logic [511:0] pw [3];

  always @(posedge clk) begin
    p1[0] <= x_in_bus[0];
    p15[0] <= x_in_bus[1];
    for (int i = 1; i < 15; i++) p15[i] <= p15[i-1];
    pw[0] <= x_in_bus[2];
    for (int i = 1; i < 3; i++) pw[i] <= pw[i-1];
  end
  assign x_out_bus[0] = p1[0];
  assign x_out_bus[1] = p15[14];
  assign x_out_bus[2] = pw[2];

  fft16_frame_ctrl #(.PIPE_LAT(1)) u_pl1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(x_in_ready[0]),
    .in_data(in_data_b), .fft_start(x_fft_start[0]), .fft_in_bus(x_in_bus[0]),
    .fft_out_bus(x_out_bus[0]), .out_valid(x_out_valid[0]), .out_ready(out_ready_b),
    .out_data(x_out_data[0]), .out_idx(x_out_idx[0]), .frame_done(x_fd[0])
  );
  fft16_frame_ctrl #(.PIPE_LAT(15)) u_pl15 (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(x_in_ready[1]),
    .in_data(in_data_b), .fft_start(x_fft_start[1]), .fft_in_bus(x_in_bus[1]),
    .fft_out_bus(x_out_bus[1]), .out_valid(x_out_valid[1]), .out_ready(out_ready_b),
    .out_data(x_out_data[1]), .out_idx(x_out_idx[1]), .frame_done(x_fd[1])
  );
  fft16_frame_ctrl #(.PIPE_LAT(2)) u_wrong (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(x_in_ready[2]),
    .in_data(in_data_b), .fft_start(x_fft_start[2]), .fft_in_bus(x_in_bus[2]),
    .fft_out_bus(x_out_bus[2]), .out_valid(x_out_valid[2]), .out_ready(out_ready_b),
    .out_data(x_out_data[2]), .out_idx(x_out_idx[2]), .frame_done(x_fd[2])
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event logs for the main instance, sampled mid-cycle.
  int          tr_idx [$];
  logic [31:0] tr_data [$];
  bit          tr_fd [$];
  int          tr_cyc [$];
  int          acc_cyc [$];
  int          start_cyc [$];
  int          fd_cyc [$];

  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) acc_cyc.push_back(cyc);
      if (fft_start) start_cyc.push_back(cyc);
      if (out_valid && out_ready) begin
        tr_idx.push_back(int'(out_idx));
        tr_data.push_back(out_data);
        tr_fd.push_back(frame_done);
        tr_cyc.push_back(cyc);
      end
      if (frame_done) fd_cyc.push_back(cyc);
    end
  end

  logic [31:0] x_got [3][16];
  int x_cnt [3];
  int x_start [3];
  int x_first [3];

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        x_cnt[i] <= 0;
        x_start[i] <= -1;
        x_first[i] <= -1;
      end else begin
        if (x_fft_start[i]) x_start[i] <= cyc;
        if (x_out_valid[i]) begin
          if (x_first[i] < 0) x_first[i] <= cyc;
          x_got[i][x_out_idx[i]] <= x_out_data[i];
          x_cnt[i] <= x_cnt[i] + 1;
        end
      end
    end
  end

  logic [15:0] fa [16];
  logic [15:0] fb [16];
  int checks = 0;
  int errors = 0;

  function automatic logic [3:0] bitrev4(input logic [3:0] k);
    return {k[0], k[1], k[2], k[3]};
  endfunction

  function automatic logic [31:0] exp_word(input bit use_b, input int k);
    logic [3:0] r;
    r = bitrev4(4'(k));
    return {(use_b ? fb[r] : fa[r]), 16'h0000};
  endfunction

  function automatic logic [511:0] bus_of_a();
    logic [511:0] b;
    for (int j = 0; j < 16; j++) b[32*j +: 32] = {fa[j], 16'h0000};
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    tr_idx.delete(); tr_data.delete(); tr_fd.delete(); tr_cyc.delete();
    acc_cyc.delete(); start_cyc.delete(); fd_cyc.delete();
  endtask

  task automatic send(input bit use_b, input int n, input bit gaps, input bit keep);
    int i = 0;
    int guard = 0;
    bit phase = 1'b0;
    while (i < n && guard < 400) begin
      guard++;
      if (gaps && phase) begin
        in_valid = 1'b0;
        phase = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data = use_b ? fb[i] : fa[i];
        phase = 1'b1;
        if (in_ready) i++;
      end
      tick();
    end
    if (!keep) in_valid = 1'b0;
    checks++;
    if (i != n) begin
      errors++;
      $display("[TB] FAIL send: accepted %0d samples, required %0d", i, n);
    end
  endtask

  task automatic wait_tr(input int n, input int limit);
    int g = 0;
    while (tr_idx.size() < n && g < limit) begin
      tick();
      g++;
    end
    checks++;
    if (tr_idx.size() < n) begin
      errors++;
      $display("[TB] FAIL wait_tr: got %0d transfers, required %0d", tr_idx.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    checks += 7;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_in_ready: got %b, expected 0", in_ready); end
    if (fft_start !== 1'b0) begin errors++; $display("[TB] FAIL rst_fft_start: got %b, expected 0", fft_start); end
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid: got %b, expected 0", out_valid); end
    if (out_idx !== 4'd0) begin errors++; $display("[TB] FAIL rst_out_idx: got %0d, expected 0", out_idx); end
    if (out_data !== 32'd0) begin errors++; $display("[TB] FAIL rst_out_data: got %h, expected 0", out_data); end
    if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL rst_frame_done: got %b, expected 0", frame_done); end
    if (fft_in_bus !== 512'd0) begin errors++; $display("[TB] FAIL rst_fft_in_bus: got %h, expected 0", fft_in_bus); end
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_rst_in_ready: got %b, expected 1", in_ready); end
  endtask

  task automatic test_basic();
    clear_logs();
    out_ready = 1'b1;
    send(1'b0, 16, 1'b0, 1'b0);
    wait_tr(16, 60);
    checks++;
    if (start_cyc.size() != 1 || acc_cyc.size() != 16) begin
      errors++; $display("[TB] FAIL basic_counts: starts %0d accepts %0d, expected 1 and 16", start_cyc.size(), acc_cyc.size());
    end else begin
      checks += 2;
      if (start_cyc[0] != acc_cyc[15] + 1) begin errors++; $display("[TB] FAIL basic_start_cycle: got %0d, expected %0d", start_cyc[0], acc_cyc[15] + 1); end
      if (tr_cyc.size() < 1 || tr_cyc[0] != start_cyc[0] + PL + 1) begin errors++; $display("[TB] FAIL basic_first_valid: got cycle %0d, expected %0d", (tr_cyc.size() > 0) ? tr_cyc[0] : -1, start_cyc[0] + PL + 1); end
    end
    for (int k = 0; k < 16 && k < tr_idx.size(); k++) begin
      checks += 3;
      if (tr_idx[k] != k) begin errors++; $display("[TB] FAIL basic_idx[%0d]: got %0d, expected %0d", k, tr_idx[k], k); end
      if (tr_data[k] !== exp_word(1'b0, k)) begin errors++; $display("[TB] FAIL basic_data[%0d]: got %h, expected %h", k, tr_data[k], exp_word(1'b0, k)); end
      if (tr_fd[k] != (k == 15)) begin errors++; $display("[TB] FAIL basic_frame_done[%0d]: got %b, expected %b", k, tr_fd[k], k == 15); end
    end
    if (tr_data.size() >= 4) begin
      checks += 2;
      if (tr_data[1] !== 32'h0800_0000) begin errors++; $display("[TB] FAIL basic_idx1: got %h, expected 08000000", tr_data[1]); end
      if (tr_data[3] !== 32'h0C00_0000) begin errors++; $display("[TB] FAIL basic_idx3: got %h, expected 0c000000", tr_data[3]); end
    end
    checks += 2;
    if (fd_cyc.size() != 1) begin errors++; $display("[TB] FAIL basic_fd_count: got %0d, expected 1", fd_cyc.size()); end
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_ready_after: got %b, expected 1", in_ready); end
  endtask

  task automatic test_gaps();
    clear_logs();
    out_ready = 1'b0;
    send(1'b0, 16, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      in_valid = ~in_valid;
      in_data = 16'hDEAD;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL gaps_in_ready[%0d]: got %b, expected 0", i, in_ready); end
      if (i < 2) begin
        checks++;
        if (fft_in_bus !== bus_of_a()) begin errors++; $display("[TB] FAIL gaps_bus_hold[%0d]: bus differs from collected frame", i); end
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_tr(16, 60);
    checks++;
    if (acc_cyc.size() != 16) begin errors++; $display("[TB] FAIL gaps_accepts: got %0d, expected 16", acc_cyc.size()); end
    for (int k = 0; k < 16 && k < tr_idx.size(); k++) begin
      checks += 2;
      if (tr_idx[k] != k) begin errors++; $display("[TB] FAIL gaps_idx[%0d]: got %0d, expected %0d", k, tr_idx[k], k); end
      if (tr_data[k] !== exp_word(1'b0, k)) begin errors++; $display("[TB] FAIL gaps_data[%0d]: got %h, expected %h", k, tr_data[k], exp_word(1'b0, k)); end
    end
  endtask

  task automatic test_stall();
    int g = 0;
    clear_logs();
    out_ready = 1'b1;
    send(1'b1, 16, 1'b0, 1'b0);
    while (!(out_valid && out_idx == 4'd5) && g < 100) begin
      tick();
      g++;
    end
    checks++;
    if (!(out_valid && out_idx == 4'd5)) begin
      errors++; $display("[TB] FAIL stall_reach_idx5: got idx %0d valid %b, expected idx 5 valid 1", out_idx, out_valid);
    end
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks += 3;
      if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid[%0d]: got %b, expected 1", i, out_valid); end
      if (out_idx !== 4'd5) begin errors++; $display("[TB] FAIL stall_idx[%0d]: got %0d, expected 5", i, out_idx); end
      if (out_data !== exp_word(1'b1, 5)) begin errors++; $display("[TB] FAIL stall_data[%0d]: got %h, expected %h", i, out_data, exp_word(1'b1, 5)); end
      if (i < 3) tick();
    end
    out_ready = 1'b1;
    wait_tr(16, 60);
    for (int k = 0; k < 16 && k < tr_idx.size(); k++) begin
      checks += 2;
      if (tr_idx[k] != k) begin errors++; $display("[TB] FAIL stall_seq[%0d]: got %0d, expected %0d", k, tr_idx[k], k); end
      if (tr_data[k] !== exp_word(1'b1, k)) begin errors++; $display("[TB] FAIL stall_out[%0d]: got %h, expected %h", k, tr_data[k], exp_word(1'b1, k)); end
    end
  endtask

  task automatic test_reset_mid();
    int g = 0;
    int n;
    clear_logs();
    out_ready = 1'b1;
    send(1'b0, 9, 1'b0, 1'b0);
    rst = 1'b1;
    tick(); tick();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL midrst_in_ready: got %b, expected 0", in_ready); end
    rst = 1'b0;
    tick();
    clear_logs();
    send(1'b1, 16, 1'b0, 1'b0);
    wait_tr(16, 60);
    for (int k = 0; k < 16 && k < tr_idx.size(); k++) begin
      checks++;
      if (tr_data[k] !== exp_word(1'b1, k)) begin errors++; $display("[TB] FAIL midrst_data[%0d]: got %h, expected %h", k, tr_data[k], exp_word(1'b1, k)); end
    end
    clear_logs();
    send(1'b0, 16, 1'b0, 1'b0);
    while (!(out_valid && out_idx == 4'd7) && g < 100) begin
      tick();
      g++;
    end
    checks++;
    if (out_idx !== 4'd7) begin errors++; $display("[TB] FAIL drainrst_reach: got idx %0d, expected 7", out_idx); end
    rst = 1'b1;
    tick();
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL drainrst_valid: got %b, expected 0", out_valid); end
    if (out_idx !== 4'd0) begin errors++; $display("[TB] FAIL drainrst_idx: got %0d, expected 0", out_idx); end
    if (out_data !== 32'd0) begin errors++; $display("[TB] FAIL drainrst_data: got %h, expected 0", out_data); end
    rst = 1'b0;
    n = tr_idx.size();
    repeat (30) tick();
    checks += 2;
    if (tr_idx.size() != n) begin errors++; $display("[TB] FAIL drainrst_no_output: got %0d transfers, expected %0d", tr_idx.size(), n); end
    if (start_cyc.size() != 1) begin errors++; $display("[TB] FAIL drainrst_no_launch: got %0d starts, expected 1", start_cyc.size()); end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    out_ready = 1'b1;
    send(1'b0, 16, 1'b0, 1'b1);
    send(1'b1, 16, 1'b0, 1'b0);
    wait_tr(32, 120);
    checks += 2;
    if (acc_cyc.size() != 32) begin errors++; $display("[TB] FAIL b2b_accepts: got %0d, expected 32", acc_cyc.size()); end
    if (start_cyc.size() != 2) begin errors++; $display("[TB] FAIL b2b_starts: got %0d, expected 2", start_cyc.size()); end
    if (acc_cyc.size() > 16 && fd_cyc.size() > 0) begin
      checks++;
      if (acc_cyc[16] <= fd_cyc[0]) begin errors++; $display("[TB] FAIL b2b_second_accept: got cycle %0d, expected after %0d", acc_cyc[16], fd_cyc[0]); end
    end
    for (int k = 0; k < 32 && k < tr_idx.size(); k++) begin
      checks += 2;
      if (tr_idx[k] != k % 16) begin errors++; $display("[TB] FAIL b2b_idx[%0d]: got %0d, expected %0d", k, tr_idx[k], k % 16); end
      if (tr_data[k] !== exp_word(k >= 16, k % 16)) begin errors++; $display("[TB] FAIL b2b_data[%0d]: got %h, expected %h", k, tr_data[k], exp_word(k >= 16, k % 16)); end
    end
  endtask

  task automatic test_pipe_lat();
    int i = 0;
    int g = 0;
    rst = 1'b1; in_valid = 1'b0; in_valid_b = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    while (i < 16 && g < 100) begin
      g++;
      in_valid_b = 1'b1;
      in_data_b = fa[i];
      if (x_in_ready[0]) i++;
      tick();
    end
    in_valid_b = 1'b0;
    g = 0;
    while ((x_cnt[0] < 16 || x_cnt[1] < 16 || x_cnt[2] < 16) && g < 100) begin
      tick();
      g++;
    end
    for (int n = 0; n < 3; n++) begin
      checks++;
      if (x_cnt[n] != 16) begin errors++; $display("[TB] FAIL lat_count[%0d]: got %0d, expected 16", n, x_cnt[n]); end
    end
    checks += 2;
    if (x_first[0] - x_start[0] != 2) begin errors++; $display("[TB] FAIL lat1_capture: got %0d, expected 2", x_first[0] - x_start[0]); end
    if (x_first[1] - x_start[1] != 16) begin errors++; $display("[TB] FAIL lat15_capture: got %0d, expected 16", x_first[1] - x_start[1]); end
    for (int k = 0; k < 16; k++) begin
      checks += 2;
      if (x_got[0][k] !== exp_word(1'b0, k)) begin errors++; $display("[TB] FAIL lat1_data[%0d]: got %h, expected %h", k, x_got[0][k], exp_word(1'b0, k)); end
      if (x_got[1][k] !== exp_word(1'b0, k)) begin errors++; $display("[TB] FAIL lat15_data[%0d]: got %h, expected %h", k, x_got[1][k], exp_word(1'b0, k)); end
    end
    // A stub one cycle too slow is captured before word 15 reaches it.
    checks += 2;
    if (x_got[2][15] !== 32'h0000_0000) begin errors++; $display("[TB] FAIL wronglat_idx15: got %h, expected 00000000", x_got[2][15]); end
    if (x_got[2][1] !== 32'h0800_0000) begin errors++; $display("[TB] FAIL wronglat_idx1: got %h, expected 08000000", x_got[2][1]); end
  endtask

  initial begin
    for (int k = 0; k < 16; k++) begin
      fa[k] = 16'(k * 16'h0100);
      fb[k] = 16'(16'h1000 + k * 16'h0321);
    end
    $display("[TB] start");
    test_reset();
    test_basic();
    test_gaps();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_pipe_lat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
